mem_porta_arbiter: RTL and testbench
====================================

Name: mem_porta_arbiter

Overview:
- Shares memory port A (15-bit word address, 16-bit data, one-cycle registered read latency, write-first) between two requesters: requester 0 is the CPU data path, requester 1 is the program loader/IO master.
- Fixed priority to requester 0, plus a starvation counter that forces a grant to requester 1 after a bounded wait.
- Sits directly in front of the dual-port memory's A-side signals. Port B (instruction fetch) is not touched.

Parameters:
- ADDR_W, 15, word address width.
- DATA_W, 16, data width.
- STARVE_LIMIT, 8, number of consecutive denied cycles of requester 1 after which it is granted unconditionally; legal range 1..255.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- Req0  input  1  requester 0 access request.
- Wen0  input  1  requester 0 write (1) / read (0).
- Addr0  input  ADDR_W  requester 0 word address.
- WData0  input  DATA_W  requester 0 write data.
- Gnt0  output  1  requester 0 access accepted this cycle (combinational).
- RValid0  output  1  read data for requester 0 valid on RData (registered).
- Req1, Wen1, Addr1, WData1, Gnt1, RValid1: same as above for requester 1.
- RData  output  DATA_W  read data, shared by both requesters (equals MemRDataA).
- MemEnA  output  1  memory port A enable.
- MemWenA  output  1  memory port A write enable.
- MemAddrA  output  ADDR_W  memory port A address.
- MemWDataA  output  DATA_W  memory port A write data.
- MemRDataA  input  DATA_W  memory port A read data (registered inside the memory).

Behaviour:
- State:
  - WaitCnt: 8 bits, saturates at STARVE_LIMIT.
  - RValid0 and RValid1 flops.
  - No other state.
- Grant equations, evaluated every cycle:
  - Gnt1 = ~reset & Req1 & (~Req0 | WaitCnt == STARVE_LIMIT).
  - Gnt0 = ~reset & Req0 & ~Gnt1.
  - At most one grant is active per cycle.
- WaitCnt update:
  - Cleared when Gnt1 or ~Req1.
  - Otherwise incremented, saturating at STARVE_LIMIT.
  - Reset value 0.
  - With both requesters continuously requesting, the grant sequence is STARVE_LIMIT cycles of Gnt0, then one Gnt1, repeating.
- Memory drive, combinational:
  - MemEnA = Gnt0 | Gnt1.
  - MemWenA, MemAddrA and MemWDataA are taken from the granted requester.
  - MemWenA = 0 when no grant. MemAddrA and MemWDataA = 0 when no grant.
- Read return:
  - RValidN <= GntN & ~WenN.
  - RValidN is asserted exactly one cycle after a granted read.
  - Writes never raise RValid.
  - RData = MemRDataA, meaningful only while an RValid is high.
  - RValid0 and RValid1 are never high together.
- Handshake:
  - A requester holds Req, Wen, Addr and WData stable until it sees Gnt high.
  - The transfer completes in the Gnt cycle (the memory samples on the following edge).
  - The requester may keep Req high with new Addr/Wen/WData in the next cycle, giving back-to-back accesses at one per cycle.
  - Dropping Req before Gnt withdraws the request. It also clears WaitCnt for requester 1.
- Throughput:
  - A single requester gets one access per cycle.
  - A read followed immediately by a write to the same address returns the old data on RValid.
- Reset:
  - Asynchronous. WaitCnt = 0, RValid0 = RValid1 = 0.
  - Gnt0, Gnt1 and MemEnA are forced to 0 while reset is high.
  - A read granted in the cycle reset asserts produces no RValid; its data is discarded.
  - After reset deasserts, the first rising edge is a normal arbitration cycle.
- Boundaries:
  - Address 0 and address 2^ADDR_W-1 pass through unmodified.
  - STARVE_LIMIT=1 gives strict alternation under full contention.

Test Plan:
1. Reset, then Req0 read at Addr0=0x0010 with memory preloaded to 0xBEEF → Gnt0=1 same cycle, MemEnA=1, MemAddrA=0x0010; next cycle RValid0=1, RData=0xBEEF, RValid1=0.
2. Req1 write Addr1=0x7FFF, WData1=0x1234, Req0 idle → Gnt1 same cycle, MemWenA=1, no RValid1; subsequent Req0 read of 0x7FFF returns 0x1234.
3. Req0 and Req1 held high with reads, STARVE_LIMIT=8 → Gnt0 for 8 cycles, Gnt1 on the 9th, pattern repeats; RValid1 exactly one cycle after each Gnt1.
4. Req1 high for 5 cycles under contention, then dropped for 1 cycle, then reasserted → WaitCnt restarts from 0; Gnt1 only after 8 further denied cycles.
5. Back-to-back Req0 reads at 0x0001, 0x0002, 0x0003 on consecutive cycles → three consecutive Gnt0, then three consecutive RValid0 with the matching data.
6. Reset asserted asynchronously mid-cycle during a granted read with WaitCnt=5 → Gnt0, MemEnA and RValid0 go to 0 immediately; WaitCnt=0; after release, the contention pattern restarts with a full 8 cycles of Gnt0.

Source files
------------

// File: rtl/mem_porta_arbiter.sv
// Port A arbiter for the shared dual-port memory.
// Requester 0 (CPU data path) has fixed priority. Requester 1 (loader/IO
// master) is granted unconditionally once it has been denied STARVE_LIMIT
// consecutive cycles. Grants and memory drive are combinational. Read
// valids are registered to line up with the memory's one-cycle read latency.
module mem_porta_arbiter #(
    parameter int unsigned ADDR_W       = 15,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Req0,
    input  logic              Wen0,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [DATA_W-1:0] WData0,
    output logic              Gnt0,
    output logic              RValid0,
    input  logic              Req1,
    input  logic              Wen1,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] WData1,
    output logic              Gnt1,
    output logic              RValid1,
    output logic [DATA_W-1:0] RData,
    output logic              MemEnA,
    output logic              MemWenA,
    output logic [ADDR_W-1:0] MemAddrA,
    output logic [DATA_W-1:0] MemWDataA,
    input  logic [DATA_W-1:0] MemRDataA
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] wait_cnt;
    logic       at_limit;

    // Grant decision: requester 1 wins when requester 0 is idle or it has starved.
    always_comb begin
        at_limit = (wait_cnt == LIMIT);
        Gnt1     = ~reset & Req1 & (~Req0 | at_limit);
        Gnt0     = ~reset & Req0 & ~Gnt1;
    end

    // Route the granted requester onto the memory port; all-zero when idle.
    always_comb begin
        MemEnA    = Gnt0 | Gnt1;
        MemWenA   = 1'b0;
        MemAddrA  = '0;
        MemWDataA = '0;
        if (Gnt0) begin
            MemWenA   = Wen0;
            MemAddrA  = Addr0;
            MemWDataA = WData0;
        end else if (Gnt1) begin
            MemWenA   = Wen1;
            MemAddrA  = Addr1;
            MemWDataA = WData1;
        end
    end

    // Count consecutive denied cycles of requester 1, saturating at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (Gnt1 || !Req1) begin
            wait_cnt <= '0;
        end else if (!at_limit) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Flag read data one cycle after a granted read; writes never flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RValid0 <= 1'b0;
            RValid1 <= 1'b0;
        end else begin
            RValid0 <= Gnt0 & ~Wen0;
            RValid1 <= Gnt1 & ~Wen1;
        end
    end

    // Read data is shared by both requesters and comes straight from the memory.
    always_comb begin
        RData = MemRDataA;
    end

endmodule

// File: tb/tb_mem_porta_arbiter.sv
// Self-checking bench for mem_porta_arbiter: table vectors, hand-written
// contention/reset sequences and a randomized run against a behavioural model.
module tb_mem_porta_arbiter;

    localparam int AW    = 15;
    localparam int DW    = 16;
    localparam int LIMIT = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          Req0 = 1'b0, Wen0 = 1'b0, Req1 = 1'b0, Wen1 = 1'b0;
    logic [AW-1:0] Addr0 = '0, Addr1 = '0;
    logic [DW-1:0] WData0 = '0, WData1 = '0;
    logic          Gnt0, Gnt1, RValid0, RValid1, MemEnA, MemWenA;
    logic [AW-1:0] MemAddrA;
    logic [DW-1:0] RData, MemWDataA, MemRDataA;

    logic          alt_gnt0, alt_gnt1, alt_rv0, alt_rv1, alt_en, alt_wen;
    logic [AW-1:0] alt_addr;
    logic [DW-1:0] alt_rdata, alt_wdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_porta_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .Req0(Req0), .Wen0(Wen0), .Addr0(Addr0), .WData0(WData0),
        .Gnt0(Gnt0), .RValid0(RValid0),
        .Req1(Req1), .Wen1(Wen1), .Addr1(Addr1), .WData1(WData1),
        .Gnt1(Gnt1), .RValid1(RValid1),
        .RData(RData), .MemEnA(MemEnA), .MemWenA(MemWenA),
        .MemAddrA(MemAddrA), .MemWDataA(MemWDataA), .MemRDataA(MemRDataA)
    );

    // Second instance with the tightest starvation limit, sharing the inputs.
    mem_porta_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(1)) dut_alt (
        .clk(clk), .reset(reset),
        .Req0(Req0), .Wen0(Wen0), .Addr0(Addr0), .WData0(WData0),
        .Gnt0(alt_gnt0), .RValid0(alt_rv0),
        .Req1(Req1), .Wen1(Wen1), .Addr1(Addr1), .WData1(WData1),
        .Gnt1(alt_gnt1), .RValid1(alt_rv1),
        .RData(alt_rdata), .MemEnA(alt_en), .MemWenA(alt_wen),
        .MemAddrA(alt_addr), .MemWDataA(alt_wdata), .MemRDataA('0)
    );

    // Initial memory contents as a function of address.
    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        if (a == 15'h0010) return 16'hBEEF;
        return 16'(32'(a) * 3 + 32'hA000);
    endfunction

    // Behavioural write-first memory with one-cycle registered read.
    logic [DW-1:0] mem_data [0:(1<<AW)-1];
    bit            mem_vld  [0:(1<<AW)-1];
    logic [DW-1:0] mem_q = '0;
    assign MemRDataA = mem_q;
    always @(posedge clk) begin
        if (MemEnA) begin
            if (MemWenA) begin
                mem_data[MemAddrA] <= MemWDataA;
                mem_vld[MemAddrA]  <= 1'b1;
                mem_q              <= MemWDataA;
            end else begin
                mem_q <= mem_vld[MemAddrA] ? mem_data[MemAddrA] : init_val(MemAddrA);
            end
        end
    end

    // Reference model state: shadow memory, starvation count, expected read return.
    logic [DW-1:0] sh_data [0:(1<<AW)-1];
    bit            sh_vld  [0:(1<<AW)-1];
    int            m_wait = 0;
    logic [DW-1:0] m_rd = '0;
    bit act_g0, act_g1, act_alt0, act_alt1, act_rv0, act_rv1;
    logic [DW-1:0] act_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One arbitration cycle: drive after negedge, check against the model,
    // cross the posedge, then check the read return.
    task automatic cycle(input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input bit r1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        bit g0, g1, rv0, rv1;
        logic [AW-1:0] ga;
        Req0 = r0; Wen0 = w0; Addr0 = a0; WData0 = d0;
        Req1 = r1; Wen1 = w1; Addr1 = a1; WData1 = d1;
        #1;
        g1 = r1 && (!r0 || m_wait == LIMIT);
        g0 = r0 && !g1;
        act_g0 = Gnt0; act_g1 = Gnt1; act_alt0 = alt_gnt0; act_alt1 = alt_gnt1;
        check("gnt0", 32'(Gnt0), 32'(g0));
        check("gnt1", 32'(Gnt1), 32'(g1));
        check("mem_en", 32'(MemEnA), 32'(g0 | g1));
        check("mem_wen", 32'(MemWenA), 32'(g0 ? w0 : (g1 ? w1 : 1'b0)));
        check("mem_addr", 32'(MemAddrA), g0 ? 32'(a0) : (g1 ? 32'(a1) : 32'd0));
        check("mem_wdata", 32'(MemWDataA), g0 ? 32'(d0) : (g1 ? 32'(d1) : 32'd0));
        @(posedge clk);
        rv0 = g0 && !w0;
        rv1 = g1 && !w1;
        if (g0 || g1) begin
            ga = g0 ? a0 : a1;
            if (g0 ? w0 : w1) begin
                sh_data[ga] = g0 ? d0 : d1;
                sh_vld[ga]  = 1'b1;
            end else begin
                m_rd = sh_vld[ga] ? sh_data[ga] : init_val(ga);
            end
        end
        if (g1 || !r1) m_wait = 0;
        else if (m_wait < LIMIT) m_wait = m_wait + 1;
        #1;
        act_rv0 = RValid0; act_rv1 = RValid1; act_rd = RData;
        check("rvalid0", 32'(RValid0), 32'(rv0));
        check("rvalid1", 32'(RValid1), 32'(rv1));
        if (rv0 || rv1) check("rdata", 32'(RData), 32'(m_rd));
        @(negedge clk);
    endtask

    typedef struct {
        bit r0; bit w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
        bit r1; bit w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
        bit g0; bit g1; bit rv0; bit rv1; logic [DW-1:0] rd;
    } vec_t;

    vec_t vecs [12];

    initial begin
        // Test plan 1, 2, 5 and the address boundaries as constant vectors.
        vecs[0]  = '{1,0,15'h0010,16'h0, 0,0,15'h0,16'h0,       1,0,1,0,16'hBEEF};
        vecs[1]  = '{0,0,15'h0,16'h0,    1,1,15'h7FFF,16'h1234, 0,1,0,0,16'h0};
        vecs[2]  = '{1,0,15'h7FFF,16'h0, 0,0,15'h0,16'h0,       1,0,1,0,16'h1234};
        vecs[3]  = '{1,0,15'h0001,16'h0, 0,0,15'h0,16'h0,       1,0,1,0,16'hA003};
        vecs[4]  = '{1,0,15'h0002,16'h0, 0,0,15'h0,16'h0,       1,0,1,0,16'hA006};
        vecs[5]  = '{1,0,15'h0003,16'h0, 0,0,15'h0,16'h0,       1,0,1,0,16'hA009};
        vecs[6]  = '{0,0,15'h0,16'h0,    0,0,15'h0,16'h0,       0,0,0,0,16'h0};
        vecs[7]  = '{0,0,15'h0,16'h0,    1,0,15'h0000,16'h0,    0,1,0,1,16'hA000};
        vecs[8]  = '{1,0,15'h0020,16'h0, 0,0,15'h0,16'h0,       1,0,1,0,16'hA060};
        vecs[9]  = '{1,1,15'h0020,16'h2222, 0,0,15'h0,16'h0,    1,0,0,0,16'h0};
        vecs[10] = '{1,0,15'h0020,16'h0, 0,0,15'h0,16'h0,       1,0,1,0,16'h2222};
        vecs[11] = '{1,1,15'h0000,16'h7777, 1,1,15'h7FFF,16'h8888, 1,0,0,0,16'h0};

        // Reset state with requests pending.
        Req0 = 1'b1; Req1 = 1'b1;
        #2;
        check("reset_gnt0", 32'(Gnt0), 32'd0);
        check("reset_gnt1", 32'(Gnt1), 32'd0);
        check("reset_mem_en", 32'(MemEnA), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_rvalid0", 32'(RValid0), 32'd0);
        check("reset_rvalid1", 32'(RValid1), 32'd0);
        Req0 = 1'b0; Req1 = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            cycle(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
                  vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
            check("vec_gnt0", 32'(act_g0), 32'(vecs[i].g0));
            check("vec_gnt1", 32'(act_g1), 32'(vecs[i].g1));
            check("vec_rvalid0", 32'(act_rv0), 32'(vecs[i].rv0));
            check("vec_rvalid1", 32'(act_rv1), 32'(vecs[i].rv1));
            if (vecs[i].rv0 || vecs[i].rv1) check("vec_rdata", 32'(act_rd), 32'(vecs[i].rd));
        end

        // Full contention: LIMIT grants to 0, then one to 1; limit-1 instance alternates.
        cycle(0,0,'0,'0, 0,0,'0,'0);
        for (int k = 0; k < 3 * (LIMIT + 1); k++) begin
            cycle(1,0,15'(k),'0, 1,0,15'(k+500),'0);
            check("cont_gnt1", 32'(act_g1), 32'((k % (LIMIT + 1)) == LIMIT));
            check("cont_rvalid1", 32'(act_rv1), 32'((k % (LIMIT + 1)) == LIMIT));
            if (k < 6) begin
                check("alt_gnt0", 32'(act_alt0), 32'((k % 2) == 0));
                check("alt_gnt1", 32'(act_alt1), 32'((k % 2) == 1));
            end
        end

        // Withdrawn request restarts the starvation count.
        cycle(0,0,'0,'0, 0,0,'0,'0);
        for (int k = 0; k < 5; k++) cycle(1,0,15'h40,'0, 1,0,15'h41,'0);
        cycle(1,0,15'h40,'0, 0,0,15'h41,'0);
        for (int k = 0; k < LIMIT + 1; k++) begin
            cycle(1,0,15'h40,'0, 1,0,15'h41,'0);
            check("restart_gnt1", 32'(act_g1), 32'(k == LIMIT));
        end

        // Asynchronous reset during a granted read with five denied cycles counted.
        cycle(0,0,'0,'0, 0,0,'0,'0);
        for (int k = 0; k < 5; k++) cycle(1,0,15'h50,'0, 1,0,15'h51,'0);
        #1;
        check("pre_rst_gnt0", 32'(Gnt0), 32'd1);
        check("pre_rst_rvalid0", 32'(RValid0), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_gnt0", 32'(Gnt0), 32'd0);
        check("rst_mem_en", 32'(MemEnA), 32'd0);
        check("rst_rvalid0", 32'(RValid0), 32'd0);
        @(posedge clk);
        #1;
        check("rst_rvalid0_edge", 32'(RValid0), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        m_wait = 0;
        for (int k = 0; k < LIMIT + 1; k++) begin
            cycle(1,0,15'h50,'0, 1,0,15'h51,'0);
            check("post_rst_gnt1", 32'(act_g1), 32'(k == LIMIT));
        end

        // Randomized traffic; a requester holds its request until granted.
        begin
            bit r0 = 0, w0 = 0, r1 = 0, w1 = 0;
            logic [AW-1:0] a0 = '0, a1 = '0;
            logic [DW-1:0] d0 = '0, d1 = '0;
            int s;
            for (int k = 0; k < 400; k++) begin
                if (!r0 || act_g0 || ($urandom_range(0, 9) == 0)) begin
                    r0 = ($urandom_range(0, 3) != 0);
                    w0 = $urandom_range(0, 1) == 1;
                    s  = $urandom_range(0, 9);
                    a0 = (s == 0) ? 15'h0 : (s == 1) ? 15'h7FFF : 15'(s + 100);
                    d0 = 16'($urandom);
                end
                if (!r1 || act_g1 || ($urandom_range(0, 19) == 0)) begin
                    r1 = ($urandom_range(0, 2) != 0);
                    w1 = $urandom_range(0, 1) == 1;
                    s  = $urandom_range(0, 9);
                    a1 = (s == 0) ? 15'h0 : (s == 1) ? 15'h7FFF : 15'(s + 100);
                    d1 = 16'($urandom);
                end
                cycle(r0, w0, a0, d0, r1, w1, a1, d1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
